// File: rtl/macs_array_if.sv
// Beat/result handshake bundle between Control (master) and macs_array (slave).
interface macs_array_if #(
  parameter int LANES   = 4,
  parameter int A_WIDTH = 8,
  parameter int B_WIDTH = 16
);
  logic [1:0]               level;
  logic                     in_valid;
  logic                     in_ready;
  logic [LANES*A_WIDTH-1:0] a;
  logic [LANES*B_WIDTH-1:0] b;
  logic [LANES*B_WIDTH-1:0] c;
  logic                     mode;
  logic                     signal;
  logic                     first;
  logic                     last;
  logic                     out_valid;
  logic                     out_ready;
  logic [LANES*B_WIDTH-1:0] result;

  modport master (
    output level, in_valid, a, b, c, mode, signal, first, last, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  level, in_valid, a, b, c, mode, signal, first, last, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/macs_array.sv
// LANES-wide multiply-add/subtract unit with accumulate runs and per-level modulus masking.
// Stage 1 registers the truncated products, stage 2 adds/accumulates into the result register.
module macs_array #(
  parameter int LANES     = 4,
  parameter int A_WIDTH   = 8,
  parameter int B_WIDTH   = 16,
  parameter int CNT_WIDTH = 11
) (
  input  logic                 clk,
  input  logic                 rstn,
  macs_array_if.slave          bus,
  output logic [CNT_WIDTH-1:0] beat_cnt,
  output logic                 err
);

  logic                       stall;
  logic                       accept;
  logic                       s1_valid;
  logic                       s1_mode;
  logic                       s1_signal;
  logic                       s1_first;
  logic                       s1_last;
  logic [1:0]                 s1_level;
  logic [B_WIDTH-1:0]         s1_prod [LANES];
  logic [B_WIDTH-1:0]         s1_c    [LANES];
  logic [B_WIDTH-1:0]         acc     [LANES];
  logic signed [B_WIDTH-1:0]  a_ext   [LANES];
  logic [B_WIDTH-1:0]         prod    [LANES];
  logic [B_WIDTH-1:0]         base    [LANES];
  logic [B_WIDTH-1:0]         sum     [LANES];
  logic                       run_open;
  logic                       start;
  logic                       bad_first;
  logic                       emit;
  logic                       out_valid_q;
  logic [LANES*B_WIDTH-1:0]   result_q;

  // A held result freezes the whole pipeline, so nothing can overtake it.
  assign stall        = out_valid_q && !bus.out_ready;
  assign bus.in_ready = rstn && !stall;
  assign accept       = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;

  // Level 0 works mod 2^15, every other level mod 2^16.
  function automatic logic [B_WIDTH-1:0] mask_q(input logic [B_WIDTH-1:0] v,
                                                input logic [1:0]         lvl);
    logic [B_WIDTH-1:0] m;
    for (int j = 0; j < B_WIDTH; j++) begin
      m[j] = (j < ((lvl == 2'd0) ? 15 : 16));
    end
    return v & m;
  endfunction

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      a_ext[i] = B_WIDTH'($signed(bus.a[i*A_WIDTH +: A_WIDTH]));
      prod[i]  = a_ext[i] * bus.b[i*B_WIDTH +: B_WIDTH];
    end
  end

  // A run that was never opened, or a first beat, starts from the addend.
  always_comb begin
    start     = s1_first || !run_open;
    bad_first = (s1_first && run_open) || (!s1_first && !run_open);
    emit      = !s1_mode || s1_last;
    for (int i = 0; i < LANES; i++) begin
      base[i] = (s1_mode && !start) ? acc[i] : s1_c[i];
      sum[i]  = s1_signal ? (base[i] - s1_prod[i]) : (base[i] + s1_prod[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_valid    <= 1'b0;
      s1_mode     <= 1'b0;
      s1_signal   <= 1'b0;
      s1_first    <= 1'b0;
      s1_last     <= 1'b0;
      s1_level    <= 2'd0;
      run_open    <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      beat_cnt    <= '0;
      err         <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        s1_prod[i] <= '0;
        s1_c[i]    <= '0;
        acc[i]     <= '0;
      end
    end else if (!stall) begin
      s1_valid  <= accept;
      s1_mode   <= bus.mode;
      s1_signal <= bus.signal;
      s1_first  <= bus.first;
      s1_last   <= bus.last;
      s1_level  <= bus.level;
      for (int i = 0; i < LANES; i++) begin
        s1_prod[i] <= prod[i];
        s1_c[i]    <= bus.c[i*B_WIDTH +: B_WIDTH];
      end

      out_valid_q <= s1_valid && emit;
      if (s1_valid) begin
        if (emit) begin
          for (int i = 0; i < LANES; i++) begin
            result_q[i*B_WIDTH +: B_WIDTH] <= mask_q(sum[i], s1_level);
          end
        end
        if (s1_mode) begin
          for (int i = 0; i < LANES; i++) begin
            acc[i] <= sum[i];
          end
          run_open <= !s1_last;
          err      <= err || bad_first;
          if (start) begin
            beat_cnt <= CNT_WIDTH'(1);
          end else if (beat_cnt != '1) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_macs_array.sv
// Randomised bench for macs_array: a 4-lane and an 8-lane instance share one stimulus stream
// and are each checked against a transaction-level arithmetic model.
module tb_macs_array;
  localparam int AW      = 8;
  localparam int BW      = 16;
  localparam int CW      = 11;
  localparam int L4      = 4;
  localparam int L8      = 8;
  localparam int RW      = L8 * BW;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic             drv_valid, drv_mode, drv_signal, drv_first, drv_last, drv_ordy;
  logic [1:0]       drv_level;
  logic [L8*AW-1:0] drv_a;
  logic [RW-1:0]    drv_b, drv_c;

  macs_array_if #(.LANES(L4), .A_WIDTH(AW), .B_WIDTH(BW)) bus4 ();
  macs_array_if #(.LANES(L8), .A_WIDTH(AW), .B_WIDTH(BW)) bus8 ();

  logic [CW-1:0] cnt4, cnt8;
  logic          err4, err8;

  assign bus4.in_valid  = drv_valid;
  assign bus4.mode      = drv_mode;
  assign bus4.signal    = drv_signal;
  assign bus4.first     = drv_first;
  assign bus4.last      = drv_last;
  assign bus4.level     = drv_level;
  assign bus4.out_ready = drv_ordy;
  assign bus4.a         = drv_a[L4*AW-1:0];
  assign bus4.b         = drv_b[L4*BW-1:0];
  assign bus4.c         = drv_c[L4*BW-1:0];

  assign bus8.in_valid  = drv_valid;
  assign bus8.mode      = drv_mode;
  assign bus8.signal    = drv_signal;
  assign bus8.first     = drv_first;
  assign bus8.last      = drv_last;
  assign bus8.level     = drv_level;
  assign bus8.out_ready = drv_ordy;
  assign bus8.a         = drv_a;
  assign bus8.b         = drv_b;
  assign bus8.c         = drv_c;

  macs_array #(.LANES(L4), .A_WIDTH(AW), .B_WIDTH(BW), .CNT_WIDTH(CW)) dut4 (
    .clk(clk), .rstn(rstn), .bus(bus4), .beat_cnt(cnt4), .err(err4)
  );

  macs_array #(.LANES(L8), .A_WIDTH(AW), .B_WIDTH(BW), .CNT_WIDTH(CW)) dut8 (
    .clk(clk), .rstn(rstn), .bus(bus8), .beat_cnt(cnt8), .err(err8)
  );

  typedef struct packed {
    logic [RW-1:0] res;
    logic [CW-1:0] cnt;
    logic          err;
  } exp_t;

  exp_t q4[$];
  exp_t q8[$];
  int   total;
  int   bad;
  int   m_acc  [2][L8];
  bit   m_open [2];
  int   m_cnt  [2];
  bit   m_err  [2];
  bit   last_acc;

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q4.delete();
    q8.delete();
    for (int d = 0; d < 2; d++) begin
      m_open[d] = 1'b0;
      m_cnt[d]  = 0;
      m_err[d]  = 1'b0;
      for (int i = 0; i < L8; i++) m_acc[d][i] = 0;
    end
  endtask

  // Reference: plain integer arithmetic, reduced mod 2^16 and then mod q.
  task automatic model_beat(input int d);
    int            n, q, av, bv, cv, p, b0, val;
    bit            cont;
    exp_t          e;
    n    = (d == 0) ? L4 : L8;
    q    = (drv_level == 2'd0) ? 32768 : 65536;
    cont = drv_mode && !drv_first && m_open[d];
    e.res = '0;
    for (int i = 0; i < n; i++) begin
      av  = int'($signed(drv_a[i*AW +: AW]));
      bv  = int'(drv_b[i*BW +: BW]);
      cv  = int'(drv_c[i*BW +: BW]);
      p   = av * bv;
      b0  = cont ? m_acc[d][i] : cv;
      val = drv_signal ? (b0 - p) : (b0 + p);
      val = val & 65535;
      if (drv_mode) m_acc[d][i] = val;
      e.res[i*BW +: BW] = BW'(val % q);
    end
    if (drv_mode) begin
      if (!drv_first && !m_open[d]) m_err[d] = 1'b1;
      if (drv_first && m_open[d]) m_err[d] = 1'b1;
      if (cont) m_cnt[d] = (m_cnt[d] + 1 > CNT_MAX) ? CNT_MAX : m_cnt[d] + 1;
      else m_cnt[d] = 1;
      m_open[d] = !drv_last;
    end
    e.cnt = CW'(m_cnt[d]);
    e.err = m_err[d];
    if (!drv_mode || drv_last) begin
      if (d == 0) q4.push_back(e);
      else q8.push_back(e);
    end
  endtask

  task automatic observe(input int d, input logic ov, input logic ir, input logic [RW-1:0] res,
                         input logic [CW-1:0] cnt, input logic er);
    exp_t e;
    int   qs;
    qs = (d == 0) ? q4.size() : q8.size();
    if (ov && !drv_ordy) begin
      checkOutput($sformatf("stall_in_ready_%0d", d), 256'(ir), 256'(0));
      if (qs > 0) begin
        e = (d == 0) ? q4[0] : q8[0];
        checkOutput($sformatf("stall_result_%0d", d), 256'(res), 256'(e.res));
      end
    end
    if (ov && drv_ordy) begin
      if (qs == 0) begin
        checkOutput($sformatf("spurious_out_%0d", d), 256'(1), 256'(0));
      end else begin
        e = (d == 0) ? q4.pop_front() : q8.pop_front();
        checkOutput($sformatf("result_%0d", d), 256'(res), 256'(e.res));
        checkOutput($sformatf("beat_cnt_%0d", d), 256'(cnt), 256'(e.cnt));
        checkOutput($sformatf("err_%0d", d), 256'(er), 256'(e.err));
      end
    end
    if (drv_valid && ir) model_beat(d);
    if (d == 1) last_acc = drv_valid && ir;
  endtask

  // Called just after a falling edge with drv_* already set; returns at the next falling edge.
  task automatic applyStimulus();
    #1;
    observe(0, bus4.out_valid, bus4.in_ready, RW'(bus4.result), cnt4, err4);
    observe(1, bus8.out_valid, bus8.in_ready, bus8.result, cnt8, err8);
    @(negedge clk);
  endtask

  task automatic set_beat(input logic v, input logic md, input logic sg, input logic fs,
                          input logic ls, input logic [1:0] lv);
    drv_valid  = v;
    drv_mode   = md;
    drv_signal = sg;
    drv_first  = fs;
    drv_last   = ls;
    drv_level  = lv;
  endtask

  task automatic rand_lanes();
    for (int i = 0; i < L8; i++) begin
      drv_a[i*AW +: AW] = AW'($urandom);
      drv_b[i*BW +: BW] = BW'($urandom);
      drv_c[i*BW +: BW] = BW'($urandom);
    end
  endtask

  task automatic set_lane0(input logic [AW-1:0] a0, input logic [BW-1:0] b0, input logic [BW-1:0] c0);
    drv_a[AW-1:0] = a0;
    drv_b[BW-1:0] = b0;
    drv_c[BW-1:0] = c0;
  endtask

  task automatic idle(input int n);
    set_beat(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
    drv_ordy = 1'b1;
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic do_reset(input int n);
    drv_valid = 1'b0;
    rstn      = 1'b0;
    model_reset();
    for (int i = 0; i < n; i++) begin
      #1;
      checkOutput("rst_in_ready", 256'(bus8.in_ready), 256'(0));
      @(negedge clk);
    end
    rstn = 1'b1;
  endtask

  // One mode-0 beat with a known lane 0, checking the two-edge latency on the way.
  task automatic single(input logic [AW-1:0] a0, input logic [BW-1:0] b0, input logic [BW-1:0] c0,
                        input logic sg, input logic [1:0] lv, input logic [BW-1:0] want,
                        input string tag);
    rand_lanes();
    set_lane0(a0, b0, c0);
    set_beat(1'b1, 1'b0, sg, 1'b0, 1'b0, lv);
    drv_ordy = 1'b1;
    applyStimulus();
    checkOutput({tag, "_edge1_valid"}, 256'(bus8.out_valid), 256'(0));
    set_beat(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, lv);
    applyStimulus();
    checkOutput({tag, "_edge2_valid"}, 256'(bus8.out_valid), 256'(1));
    checkOutput({tag, "_lane0_8"}, 256'(bus8.result[BW-1:0]), 256'(want));
    checkOutput({tag, "_lane0_4"}, 256'(bus4.result[BW-1:0]), 256'(want));
    applyStimulus();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    last_acc = 1'b0;
    rstn  = 1'b0;
    drv_ordy = 1'b1;
    drv_a = '0;
    drv_b = '0;
    drv_c = '0;
    set_beat(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    do_reset(2);

    checkOutput("rst_out_valid", 256'(bus8.out_valid), 256'(0));
    checkOutput("rst_result", 256'(bus8.result), 256'(0));
    checkOutput("rst_beat_cnt", 256'(cnt8), 256'(0));
    checkOutput("rst_err", 256'(err8), 256'(0));
    checkOutput("rst_out_valid_4", 256'(bus4.out_valid), 256'(0));

    single(8'hFF, 16'h0003, 16'h0010, 1'b0, 2'd1, 16'h000D, "m0_add");
    single(8'hFF, 16'h0003, 16'h0010, 1'b1, 2'd1, 16'h0013, "m0_sub");
    single(8'h02, 16'h4000, 16'h0000, 1'b0, 2'd1, 16'h8000, "mask_l1");
    single(8'h02, 16'h4000, 16'h0000, 1'b0, 2'd0, 16'h0000, "mask_l0");

    // Three-beat accumulate run, no gaps.
    rand_lanes(); set_lane0(8'd1, 16'd10, 16'd5);
    set_beat(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1);
    applyStimulus();
    checkOutput("acc_nv1", 256'(bus8.out_valid), 256'(0));
    rand_lanes(); set_lane0(8'd2, 16'd10, 16'd0);
    set_beat(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
    applyStimulus();
    checkOutput("acc_nv2", 256'(bus8.out_valid), 256'(0));
    rand_lanes(); set_lane0(8'hFF, 16'd4, 16'd0);
    set_beat(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1);
    applyStimulus();
    checkOutput("acc_nv3", 256'(bus8.out_valid), 256'(0));
    set_beat(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
    applyStimulus();
    checkOutput("acc_valid", 256'(bus8.out_valid), 256'(1));
    checkOutput("acc_lane0", 256'(bus8.result[BW-1:0]), 256'(16'h001F));
    checkOutput("acc_cnt", 256'(cnt8), 256'(3));
    checkOutput("acc_err", 256'(err8), 256'(0));
    idle(1);

    // Orphan continuation beat, then a restart inside an open run.
    rand_lanes(); set_lane0(8'd1, 16'd1, 16'd7);
    set_beat(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1);
    applyStimulus();
    idle(1);
    checkOutput("orphan_lane0", 256'(bus8.result[BW-1:0]), 256'(16'h0008));
    checkOutput("orphan_err", 256'(err8), 256'(1));
    idle(1);
    rand_lanes(); set_beat(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1);
    applyStimulus();
    rand_lanes(); set_beat(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1);
    set_beat(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2);
    applyStimulus();
    idle(1);
    checkOutput("restart_cnt", 256'(cnt8), 256'(1));
    checkOutput("restart_err", 256'(err8), 256'(1));
    rand_lanes(); set_beat(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3);
    applyStimulus();
    idle(3);

    // Continuous mode-0 stream with out_ready low for three cycles.
    last_acc = 1'b1;
    drv_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (last_acc || !drv_valid) begin
        rand_lanes();
        set_beat(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 2'($urandom_range(0, 3)));
      end
      drv_ordy = !(i >= 5 && i < 8);
      applyStimulus();
    end
    idle(4);

    // Reset in the middle of a run.
    rand_lanes(); set_beat(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1);
    applyStimulus();
    rand_lanes(); set_beat(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
    applyStimulus();
    do_reset(1);
    checkOutput("midrst_out_valid", 256'(bus8.out_valid), 256'(0));
    checkOutput("midrst_cnt", 256'(cnt8), 256'(0));
    checkOutput("midrst_err", 256'(err8), 256'(0));
    rand_lanes(); set_beat(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
    applyStimulus();
    idle(2);
    checkOutput("postrst_err", 256'(err8), 256'(1));
    rand_lanes(); set_beat(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1);
    applyStimulus();
    idle(3);

    // Long run to push beat_cnt past its ceiling.
    for (int i = 0; i < CNT_MAX + 3; i++) begin
      rand_lanes();
      set_beat(1'b1, 1'b1, 1'($urandom_range(0, 1)), (i == 0), (i == CNT_MAX + 2), 2'd1);
      applyStimulus();
    end
    idle(3);
    checkOutput("sat_cnt", 256'(cnt8), 256'(CNT_MAX));

    // Random traffic: mixed modes, levels, run markers and backpressure.
    last_acc = 1'b1;
    drv_valid = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (last_acc || !drv_valid) begin
        rand_lanes();
        set_beat(($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                 2'($urandom_range(0, 3)));
      end
      drv_ordy = ($urandom_range(0, 3) != 0);
      applyStimulus();
    end
    idle(10);
    checkOutput("drain_4", 256'(q4.size()), 256'(0));
    checkOutput("drain_8", 256'(q8.size()), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
